demux4_stream: RTL and testbench

- 1-to-4 registered demultiplexer with valid/ready handshake; the write-side counterpart of the 4-way datapath select.
- A single producer stream (e.g. store data from the datapath) is steered by a 2-bit select into one of four consumer lanes.
- Each lane has a one-entry holding register, so consumers can stall independently without corrupting other lanes.
- Sits between the core's store path and the memory/MMIO targets.

---
 rtl/demux4_stream.sv | 113 +++++++++++
 tb/tb_demux4_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 registered stream demultiplexer with a one-entry holding register per lane.
// Optional per-lane delivery counters are enabled with `define DEMUX4_STREAM_COUNT_EN.
module demux4_stream #(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [width-1:0]     in_data,
  input  logic [1:0]           in_select,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*width-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
`ifdef DEMUX4_STREAM_COUNT_EN
  ,
  output logic [4*16-1:0]      out_count
`endif
);

  // Handshake: a word moves on a rising edge when valid and ready are both high.
  // in_ready looks only at the selected lane and includes a combinational out_ready->in_ready path,
  // which lets a full lane be drained and refilled in the same cycle.
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

  lane_state_t      r_state [4];
  lane_state_t      w_state_nxt [4];
  logic [width-1:0] r_data [4];
  logic [3:0]       w_load;
  logic [3:0]       w_deliver;
  logic             w_accept;

  always_comb begin
    in_ready = ~reset & ((r_state[in_select] == LANE_EMPTY) | out_ready[in_select]);
    w_accept = in_valid & in_ready;
  end

  always_comb begin
    w_load    = '0;
    w_deliver = '0;
    for (int k = 0; k < 4; k++) begin
      w_load[k]    = w_accept & (in_select == 2'(k));
      w_deliver[k] = (r_state[k] == LANE_FULL) & out_ready[k];
    end
  end

  // A reload wins over a delivery so a lane can sustain one word per cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_state_nxt[k] = r_state[k];
      if (w_load[k]) begin
        w_state_nxt[k] = LANE_FULL;
      end else if (w_deliver[k]) begin
        w_state_nxt[k] = LANE_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_state[k] <= LANE_EMPTY;
        r_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_state[k] <= w_state_nxt[k];
        if (w_load[k]) begin
          r_data[k] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k]               = (r_state[k] == LANE_FULL);
      out_data[k*width +: width] = r_data[k];
    end
  end

`ifdef DEMUX4_STREAM_COUNT_EN
  logic [15:0] r_count [4];

  // Counters wrap naturally at 16 bits; a delivery during reset is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_deliver[k]) begin
          r_count[k] <= r_count[k] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    out_count = '0;
    for (int k = 0; k < 4; k++) begin
      out_count[k*16 +: 16] = r_count[k];
    end
  end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed vector table, hand-written corner sequences, random traffic,
// and a per-lane expected-data queue checked on every delivery.
module tb_demux4_stream;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic [1:0]   in_select;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef DEMUX4_STREAM_COUNT_EN
  logic [63:0]  out_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  demux4_stream #(.width(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_select (in_select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX4_STREAM_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_select = s;
    in_data   = d;
    out_ready = r;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [4][$];
  logic        m_full [4];
  logic [31:0] m_data [4];
  logic [15:0] m_cnt  [4];
  logic        exp_rdy;
  logic [31:0] exp_word;

  always @(negedge clk) begin
    exp_rdy = !reset && (!m_full[in_select] || out_ready[in_select]);
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid[%0d]", k), {63'd0, out_valid[k]}, {63'd0, m_full[k]});
      check($sformatf("out_data[%0d]", k), {32'd0, out_data[k*32 +: 32]}, {32'd0, m_data[k]});
`ifdef DEMUX4_STREAM_COUNT_EN
      check($sformatf("out_count[%0d]", k), {48'd0, out_count[k*16 +: 16]}, {48'd0, m_cnt[k]});
`endif
    end
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
        m_cnt[k]  = '0;
        exp_q[k].delete();
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL deliver[%0d]: got %0h expected no word (t=%0t)", k, out_data[k*32 +: 32], $time);
          end else begin
            exp_word = exp_q[k].pop_front();
            check($sformatf("deliver[%0d]", k), {32'd0, out_data[k*32 +: 32]}, {32'd0, exp_word});
          end
          m_full[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 16'd1;
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q[in_select].push_back(in_data);
        m_data[in_select] = in_data;
        m_full[in_select] = 1'b1;
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
  } vec_t;

  vec_t vecs [16];
  logic stall;

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, {60'd0, out_valid}, 64'd0);
    check({tag, "_out_data_lo"}, out_data[63:0], 64'd0);
    check({tag, "_out_data_hi"}, out_data[127:64], 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_select = 2'd0;
    in_data   = '0;
    out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      m_cnt[k]  = '0;
    end

    // streaming on lane 1, words 1..8, consumer always ready
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 2'd1, 32'(i + 1), 4'b0010, 1'b1, (i == 0) ? 4'b0000 : 4'b0010};
    end
    vecs[8]  = '{1'b0, 2'd1, 32'h0,  4'b0010, 1'b1, 4'b0010};
    vecs[9]  = '{1'b0, 2'd1, 32'h0,  4'b0000, 1'b1, 4'b0000};
    // stall isolation: lane 0 held full, lane 3 flows
    vecs[10] = '{1'b1, 2'd0, 32'hA0, 4'b0000, 1'b1, 4'b0000};
    vecs[11] = '{1'b1, 2'd3, 32'h55, 4'b1000, 1'b1, 4'b0001};
    vecs[12] = '{1'b0, 2'd3, 32'h0,  4'b1000, 1'b1, 4'b1001};
    vecs[13] = '{1'b1, 2'd0, 32'hB0, 4'b0000, 1'b0, 4'b0001};
    vecs[14] = '{1'b0, 2'd0, 32'h0,  4'b0001, 1'b1, 4'b0001};
    vecs[15] = '{1'b0, 2'd0, 32'h0,  4'b0000, 1'b1, 4'b0000};

    // reset held 3 cycles with a pending producer word
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 32'hAA, 4'b1111);
      @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check_all_zero("rst");
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", {60'd0, out_valid}, 64'd0);
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
    end

    // basic route to lane 2, then blocked second write
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    @(negedge clk);
    check("route_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd2, 32'h12345678, 4'b0000);
      @(negedge clk);
      check("route_out_valid", {60'd0, out_valid}, 64'h4);
      check("route_lane2", {32'd0, out_data[95:64]}, 64'hDEADBEEF);
      check("route_blocked", {63'd0, in_ready}, 64'd0);
    end
    drive(1'b0, 2'd2, 32'h0, 4'b0100);
    @(negedge clk);
    check("route_deliver_data", {32'd0, out_data[95:64]}, 64'hDEADBEEF);
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    @(negedge clk);
    check("route_empty_valid", {60'd0, out_valid}, 64'd0);
    check("route_empty_hold", {32'd0, out_data[95:64]}, 64'hDEADBEEF);

    // table vectors
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_out_valid", i), {60'd0, out_valid}, {60'd0, vecs[i].exp_ov});
    end
    check("iso_lane3", {32'd0, out_data[127:96]}, 64'h55);

    // reset mid-operation with lanes 0 and 2 full and consumers ready
    drive(1'b1, 2'd0, 32'h11, 4'b0000);
    drive(1'b1, 2'd2, 32'h22, 4'b0000);
    drive(1'b0, 2'd0, 32'h0, 4'b0101);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {60'd0, out_valid}, 64'h5);
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");

    // random traffic obeying the producer hold rule
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall = in_valid && !in_ready;
      @(posedge clk);
      #1;
      if (!stall) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_select = 2'($urandom_range(0, 3));
        in_data   = $urandom;
      end
      out_ready = 4'($urandom_range(0, 15));
    end

`ifdef DEMUX4_STREAM_COUNT_EN
    // counter wrap: 65537 deliveries on lane 3 after a clean reset
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    reset = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 2'd3, 32'(i), 4'b1000);
    end
    drive(1'b0, 2'd3, 32'h0, 4'b1000);
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    @(negedge clk);
    check("wrap_count3", {48'd0, out_count[63:48]}, 64'd1);
    check("wrap_count_others", {16'd0, out_count[47:0]}, 64'd0);
`endif

    // drain and confirm nothing is left outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 32'h0, 4'b1111);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_q[%0d]", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
